dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive contested cycles won by the core before the DMA port gets priority (legal range 1..15).
REQ-002 SHALL have parameter AW, default 32, meaning the address width of all ports.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 c_req  input  1  core access request (read when c_we=0, write when c_we=1).
REQ-007 c_we  input  1  core write enable, qualified by c_req.
REQ-008 c_addr  input  AW  core byte address.
REQ-009 c_wdata  input  32  core write data.
REQ-010 c_gnt  output  1  core access accepted this cycle; core stalls while c_req=1 and c_gnt=0.
REQ-011 c_rvalid  output  1  core read data valid on c_rdata.
REQ-012 c_rdata  output  32  core read data.
REQ-013 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  SHALL carry the same directions, widths and meanings as REQ-006..012, for the DMA/loader port.
REQ-014 mem_read  output  1  data memory read enable.
REQ-015 mem_write  output  1  data memory write enable.
REQ-016 mem_addr  output  AW  data memory address.
REQ-017 mem_write_data  output  32  data memory write data.
REQ-018 mem_read_data  input  32  data memory read data, valid the cycle after mem_read=1.

Function
REQ-019 SHALL grant at most one port per cycle; c_gnt and d_gnt SHALL never both be 1.
REQ-020 Grant SHALL be combinational from the current req inputs and the registered arbitration state (zero-cycle request-to-grant latency).
REQ-021 SHALL route the granted port's addr/wdata to mem_addr/mem_write_data and drive mem_read=~we, mem_write=we for that port; with no grant, mem_read=mem_write=0 and mem_addr/mem_write_data=0.
REQ-022 SHALL register the owner of a granted read; in the next cycle it asserts exactly that port's rvalid for one cycle, and the rdata of that port equals mem_read_data.
REQ-023 The rdata of a port SHALL be 0 whenever the rvalid of that port is 0; writes produce no rvalid.
REQ-024 SHALL implement a two-state FSM: PRI_CORE (core wins contention) and PRI_DMA (DMA wins contention).
REQ-025 Only one requester active: that requester SHALL be granted in either state.
REQ-026 In PRI_CORE, on a contested cycle, the core SHALL be granted and a 4-bit starvation counter incremented; when the incremented value equals STARVE_LIMIT, the FSM SHALL go to PRI_DMA and the counter clears.
REQ-027 In PRI_CORE, the counter SHALL clear on any cycle with d_req=0 or d_gnt=1.
REQ-028 In PRI_DMA, the FSM SHALL grant the DMA if d_req=1 and return to PRI_CORE next cycle regardless of d_req.
REQ-029 Back-to-back grants SHALL be allowed: a new access may be granted in the same cycle as the previous read's rvalid.
REQ-030 A read and a write from different ports in consecutive cycles SHALL complete without loss; the read's rvalid timing is unaffected.

Reset
REQ-031 While reset=1: c_gnt, d_gnt, mem_read and mem_write SHALL be 0, regardless of req inputs.
REQ-032 After the first reset edge: FSM=PRI_CORE, counter=0, rvalid owner cleared, so c_rvalid=d_rvalid=0 next cycle.
REQ-033 A read granted in the cycle before reset asserts SHALL produce no rvalid.

Verification
REQ-034 Core read only: c_req=1, c_we=0, c_addr=0x40, mem returns 0xDEADBEEF -> c_gnt=1, mem_read=1, mem_addr=0x40 in cycle N; c_rvalid=1, c_rdata=0xDEADBEEF in N+1; d_rvalid=0.
REQ-035 Contention, STARVE_LIMIT=4: c_req=d_req=1 held -> c_gnt in cycles 0..3, d_gnt in cycle 4, c_gnt in cycles 5..8, d_gnt in cycle 9.
REQ-036 DMA write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678, c_req=0 -> d_gnt=1, mem_write=1, mem_write_data=0x12345678 in the same cycle; no rvalid on either port.
REQ-037 Interleaving: core read at 0x8 in cycle N, DMA read at 0xC in N+1 -> c_rvalid in N+1, d_rvalid in N+2, each carrying its own data.
REQ-038 Reset during a read: grant in cycle N, reset=1 in N+1 -> c_rvalid=0 in N+1; after reset with 3 contested cycles, counter=3 and FSM still in PRI_CORE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (core / DMA) data memory arbiter with starvation guard
//
// Purpose: shares one single-port data memory between the core and the
// DMA/loader port. The core normally wins a contested cycle. After
// STARVE_LIMIT contested core wins in a row, the DMA port gets one cycle
// of priority, so the DMA port is never starved.
//
// Ports:
//   clock, reset                  sole clock; synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata     core request (read when c_we=0)
//   c_gnt                         core request accepted this cycle
//   c_rvalid/c_rdata              core read data, one cycle after the grant
//   d_*                           same signals for the DMA/loader port
//   mem_read/mem_write            data memory strobes for the granted port
//   mem_addr/mem_write_data       data memory address and write data
//   mem_read_data                 data memory read data, valid the cycle after mem_read
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_read_data
);

    typedef enum logic {
        PRI_CORE = 1'b0,
        PRI_DMA  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_core_q, rd_core_d;
    logic       rd_dma_q, rd_dma_d;
    logic [3:0] cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= PRI_CORE;
            cnt_q     <= 4'd0;
            rd_core_q <= 1'b0;
            rd_dma_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_core_q <= rd_core_d;
            rd_dma_q  <= rd_dma_d;
        end
    end

    // Arbitration FSM: grants are combinational from the requests and the
    // registered priority state. Reset forces every grant low.
    always_comb begin
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 4'd1;
        if (!reset) begin
            case (state_q)
                PRI_CORE: begin
                    if (c_req) begin
                        c_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                    if (c_req && d_req) begin
                        if (cnt_inc == LIMIT) begin
                            state_d = PRI_DMA;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Uncontested: either the DMA is idle or it just won.
                        cnt_d = 4'd0;
                    end
                end
                PRI_DMA: begin
                    if (d_req) begin
                        d_gnt = 1'b1;
                    end else if (c_req) begin
                        c_gnt = 1'b1;
                    end
                    // The DMA priority window lasts exactly one cycle.
                    state_d = PRI_CORE;
                    cnt_d   = 4'd0;
                end
                default: begin
                    state_d = PRI_CORE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Memory-side mux driven by whichever port holds the grant.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = 32'd0;
        if (c_gnt) begin
            mem_read       = ~c_we;
            mem_write      = c_we;
            mem_addr       = c_addr;
            mem_write_data = c_wdata;
        end else if (d_gnt) begin
            mem_read       = ~d_we;
            mem_write      = d_we;
            mem_addr       = d_addr;
            mem_write_data = d_wdata;
        end
    end

    // Remember which port owns the read now in flight.
    always_comb begin
        rd_core_d = c_gnt & ~c_we;
        rd_dma_d  = d_gnt & ~d_we;
    end

    // Gating with reset drops the return of a read granted just before
    // reset rises; the owner flops only clear at the following edge.
    always_comb begin
        c_rvalid = rd_core_q & ~reset;
        d_rvalid = rd_dma_q & ~reset;
        c_rdata  = c_rvalid ? mem_read_data : 32'd0;
        d_rdata  = d_rvalid ? mem_read_data : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic        rst, cq, cw;
        logic [31:0] ca, cwd;
        logic        dq, dw;
        logic [31:0] da, dwd, mrd;
        logic        e_cg, e_dg, e_mr, e_mw;
        logic [31:0] e_ma, e_mwd;
        logic        e_cv;
        logic [31:0] e_cd;
        logic        e_dv;
        logic [31:0] e_dd;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One cycle of write-only traffic (or a core read when cwe=0);
    // checks the grant decision of that cycle.
    task automatic step(input logic r, input logic cq, input logic cwe, input logic dq,
                        input logic ecg, input logic edg, input string nm);
        @(negedge clock);
        reset = r; c_req = cq; c_we = cwe; c_addr = 32'h200; c_wdata = 32'h1;
        d_req = dq; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h2;
        mem_read_data = 32'h0;
        #1;
        check({nm, " c_gnt"}, 32'(c_gnt), 32'(ecg));
        check({nm, " d_gnt"}, 32'(d_gnt), 32'(edg));
    endtask

    initial begin
        reset = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; mem_read_data = 32'h0;

        //            rst   cq    cw    ca        cwd       dq    dw    da         dwd           mrd           cg    dg    mr    mw    ma         mwd           cv    cd            dv    dd
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h0,    1'b1, 1'b0, 32'h80,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'h100, 32'h12345678, 32'hAAAA,     1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h5555,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h8,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'hC,   32'h0,        32'h1111,     1'b0, 1'b1, 1'b1, 1'b0, 32'hC,   32'h0,        1'b1, 32'h1111,     1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h2222,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b1, 32'h2222};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE, 1'b0, 1'b0, 32'h0,   32'h0,        32'h33,       1'b1, 1'b0, 1'b0, 1'b1, 32'h20,  32'hCAFE,     1'b0, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h30,  32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h30,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h34, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h44,       1'b1, 1'b0, 1'b1, 1'b0, 32'h34,  32'h0,        1'b0, 32'h0,        1'b1, 32'h44};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h38, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h55,       1'b1, 1'b0, 1'b1, 1'b0, 32'h38,  32'h0,        1'b1, 32'h55,       1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,   32'h0,        32'h66,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h66,       1'b0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            reset = vecs[i].rst; c_req = vecs[i].cq; c_we = vecs[i].cw;
            c_addr = vecs[i].ca; c_wdata = vecs[i].cwd;
            d_req = vecs[i].dq; d_we = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
            mem_read_data = vecs[i].mrd;
            #1;
            check($sformatf("v%0d c_gnt", i),     32'(c_gnt),     32'(vecs[i].e_cg));
            check($sformatf("v%0d d_gnt", i),     32'(d_gnt),     32'(vecs[i].e_dg));
            check($sformatf("v%0d mem_read", i),  32'(mem_read),  32'(vecs[i].e_mr));
            check($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_mw));
            check($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_ma);
            check($sformatf("v%0d mem_wdata", i), mem_write_data, vecs[i].e_mwd);
            check($sformatf("v%0d c_rvalid", i),  32'(c_rvalid),  32'(vecs[i].e_cv));
            check($sformatf("v%0d c_rdata", i),   c_rdata,        vecs[i].e_cd);
            check($sformatf("v%0d d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].e_dv));
            check($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_dd);
        end

        // Held contention: DMA wins every fifth cycle.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "a_rst");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, (k != 4 && k != 9), (k == 4 || k == 9),
                 $sformatf("a_cont%0d", k));
        end

        // DMA priority lasts one cycle even without d_req; d_req=0 clears the count.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "b_rst");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_c0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_c1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_c2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_c3");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "b_dma_pri_core_only");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_back_core1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_back_core2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_back_core3");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "b_clear");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_after_clear1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_after_clear2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_after_clear3");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "b_after_clear4");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "b_after_clear_dma");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "b_dma_only");

        // Reset during a read, with a part-filled starvation count.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "c_rst");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_c0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_c1");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "c_read");
        @(negedge clock);
        reset = 1'b1; c_req = 1'b1; c_we = 1'b0; d_req = 1'b1; d_we = 1'b0;
        mem_read_data = 32'h77;
        #1;
        check("c_rst_c_gnt",    32'(c_gnt),    32'h0);
        check("c_rst_d_gnt",    32'(d_gnt),    32'h0);
        check("c_rst_mem_read", 32'(mem_read), 32'h0);
        check("c_rst_c_rvalid", 32'(c_rvalid), 32'h0);
        check("c_rst_c_rdata",  c_rdata,       32'h0);
        check("c_rst_d_rvalid", 32'(d_rvalid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_post0");
        check("c_post0_c_rvalid", 32'(c_rvalid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_post1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_post2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c_post3");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "c_post4_dma");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
